// File: rtl/multi_mode_counter_pkg.sv
// Shared definitions for the multi-mode counter:
// mode encodings and Gray-code conversion helpers.
package multi_mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_GRAY    = 2'b11
  } mode_t;

  localparam int MAX_W = 16;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the stepping edge.
// step is combinational for the owner's next-state; tick is registered.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic step,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pre;

  assign step = en && (pre == LAST);

  // Prescale counter; frozen when disabled, zeroed on clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      pre  <= step ? '0 : pre + ONE;
      tick <= step;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_mode_counter.sv
// Runtime-selectable up/down/Johnson/Gray counter
// with prescaler, parallel load and terminal-count pulse.
module multi_mode_counter
  import multi_mode_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};

  mode_t            mode_q;
  logic             mode_chg;
  logic             step;
  logic [WIDTH-1:0] inv;
  logic             j_legal;
  logic [WIDTH-1:0] gb;
  logic [WIDTH-1:0] nxt;
  logic             wrap;

  assign mode_chg = (mode_t'(mode) != mode_q);
  assign inv      = ~count;
  // Legal Johnson codes are runs of ones anchored at bit 0 or the MSB
  assign j_legal  = ((count & (count + ONE)) == '0) ||
                    ((inv & (inv + ONE)) == '0);
  assign gb       = WIDTH'(gray2bin(MAX_W'(count))) + ONE;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (mode_chg || load),
    .step  (step),
    .tick  (tick)
  );

  // Next count and wrap detect for the current mode
  always_comb begin
    nxt  = count;
    wrap = 1'b0;
    unique case (mode_q)
      MODE_UP: begin
        nxt  = count + ONE;
        wrap = (count == '1);
      end
      MODE_DOWN: begin
        nxt  = count - ONE;
        wrap = (count == '0);
      end
      MODE_JOHNSON: begin
        nxt  = j_legal ? {count[WIDTH-2:0], ~count[WIDTH-1]} : '0;
        wrap = j_legal && (count == TOP);
      end
      MODE_GRAY: begin
        nxt  = WIDTH'(bin2gray(MAX_W'(gb)));
        wrap = (count == TOP);
      end
      default: begin
        nxt  = count;
        wrap = 1'b0;
      end
    endcase
  end

  // Count register: reset > mode change > load > step > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      tc     <= 1'b0;
      mode_q <= mode_t'(mode);
    end else if (mode_chg) begin
      count  <= '0;
      tc     <= 1'b0;
      mode_q <= mode_t'(mode);
    end else if (load) begin
      count  <= load_val;
      tc     <= 1'b0;
    end else if (step) begin
      count  <= nxt;
      tc     <= wrap;
    end else begin
      tc     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_mode_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 4) share stimulus,
// each checked against an arithmetic reference model.
module tb_multi_mode_counter;

  typedef struct {
    logic [3:0] c;
    logic       t;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count0, count1;
  logic       tick0, tick1, tc0, tc1;

  int compared = 0;
  int mismatched = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_mq[2];
  int m_cnt[2];
  int m_pre[2];
  int ps[2] = '{1, 4};
  int jseq[8] = '{0, 1, 3, 7, 15, 14, 12, 8};

  always #5 clk = ~clk;

  multi_mode_counter #(.WIDTH(4), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count0), .tick(tick0), .tc(tc0)
  );

  multi_mode_counter #(.WIDTH(4), .PRESCALE(4)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count1), .tick(tick1), .tc(tc1)
  );

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < 4; i++) b = b ^ (g >> i);
    return b & 15;
  endfunction

  // One clock edge of the reference behaviour for DUT d
  task automatic model(input int d, output exp_t e);
    int nc;
    bit wr;
    e.t  = 1'b0;
    e.tc = 1'b0;
    if (reset) begin
      m_cnt[d] = 0; m_pre[d] = 0; m_mq[d] = int'(mode);
    end else if (int'(mode) != m_mq[d]) begin
      m_cnt[d] = 0; m_pre[d] = 0; m_mq[d] = int'(mode);
    end else if (load) begin
      m_cnt[d] = int'(load_val); m_pre[d] = 0;
    end else if (en) begin
      if (m_pre[d] == ps[d] - 1) begin
        m_pre[d] = 0;
        e.t = 1'b1;
        nc = 0;
        wr = 1'b0;
        case (m_mq[d])
          0: begin nc = (m_cnt[d] + 1) % 16; wr = (nc == 0); end
          1: begin nc = (m_cnt[d] + 15) % 16; wr = (m_cnt[d] == 0); end
          2: begin
            for (int i = 0; i < 8; i++)
              if (jseq[i] == m_cnt[d]) begin
                nc = jseq[(i + 1) % 8];
                wr = (i == 7);
              end
          end
          default: begin
            nc = (g2b(m_cnt[d]) + 1) % 16;
            wr = (nc == 0);
            nc = nc ^ (nc >> 1);
          end
        endcase
        m_cnt[d] = nc;
        e.tc = wr;
      end else begin
        m_pre[d] = m_pre[d] + 1;
      end
    end
    e.c = 4'(m_cnt[d]);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [1:0] m,
                       input bit l, input logic [3:0] v);
    exp_t x0, x1;
    @(negedge clk);
    reset = r; en = e; mode = m; load = l; load_val = v;
    model(0, x0);
    model(1, x1);
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  // Monitor: every edge a result is due for each queued stimulus
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        chk("p1.count", int'(count0), int'(x.c));
        chk("p1.tick", int'(tick0), int'(x.t));
        chk("p1.tc", int'(tc0), int'(x.tc));
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        chk("p4.count", int'(count1), int'(x.c));
        chk("p4.tick", int'(tick1), int'(x.t));
        chk("p4.tc", int'(tc1), int'(x.tc));
      end
    end
  end

  initial begin
    int budget;
    // reset then idle hold
    repeat (2) drive(1, 0, 2'b00, 0, 4'd0);
    repeat (3) drive(0, 0, 2'b00, 0, 4'd0);
    // binary up through wrap
    repeat (17) drive(0, 1, 2'b00, 0, 4'd0);
    // Johnson full cycle
    repeat (9) drive(0, 1, 2'b10, 0, 4'd0);
    // down from loaded 2 through wrap
    drive(0, 0, 2'b01, 0, 4'd0);
    drive(0, 0, 2'b01, 1, 4'd2);
    repeat (4) drive(0, 1, 2'b01, 0, 4'd0);
    // Johnson illegal code recovery, then mode change mid-count
    drive(0, 0, 2'b10, 0, 4'd0);
    drive(0, 0, 2'b10, 1, 4'b0101);
    repeat (3) drive(0, 1, 2'b10, 0, 4'd0);
    drive(0, 1, 2'b00, 0, 4'd0);
    // prescaled stepping, freeze, reset in window
    repeat (10) drive(0, 1, 2'b00, 0, 4'd0);
    drive(0, 0, 2'b00, 0, 4'd0);
    drive(0, 0, 2'b00, 0, 4'd0);
    drive(0, 1, 2'b00, 0, 4'd0);
    drive(0, 0, 2'b00, 0, 4'd0);
    drive(1, 0, 2'b00, 0, 4'd0);
    drive(0, 0, 2'b00, 0, 4'd0);
    repeat (10) drive(0, 1, 2'b00, 0, 4'd0);
    // Gray wrap from loaded value
    drive(0, 0, 2'b11, 0, 4'd0);
    drive(0, 0, 2'b11, 1, 4'b1010);
    repeat (12) drive(0, 1, 2'b11, 0, 4'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 60) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 25) == 0) ? 2'($urandom) : mode,
            ($urandom_range(0, 12) == 0),
            4'($urandom));
    end
    budget = 20;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (q0.size() > 0 || q1.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d results left, expected 0",
               q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
